// File: rtl/activation_skew_buffer_if.sv
`default_nettype none
// ============================================================================
// activation_skew_buffer_if : vector handshake and lane bus of the skew buffer
// Revision: 1.0
// ============================================================================
interface activation_skew_buffer_if #(
  parameter int SYSTOLIC_SIZE    = 8,
  parameter int ACTIVATION_WIDTH = 8
);
  logic [1:0]                                mode;
  logic                                      valid_in;
  logic                                      ready;
  logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] activation_in_flat;
  logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] activation_out_flat;
  logic [SYSTOLIC_SIZE-1:0]                  valid_out;
  logic                                      busy;

  modport master (
    output mode, valid_in, activation_in_flat,
    input  ready, activation_out_flat, valid_out, busy
  );

  modport slave (
    input  mode, valid_in, activation_in_flat,
    output ready, activation_out_flat, valid_out, busy
  );
endinterface
`default_nettype wire

// File: rtl/activation_skew_buffer.sv
`default_nettype none
// ============================================================================
// activation_skew_buffer : per-lane skew/deskew/bypass delay lines with drain FSM
// Optional feature macro: STRAIT_DESKEW_EN (mode 10 = DESKEW, full-depth lanes)
// Revision: 1.0
// ============================================================================
module activation_skew_buffer #(
  parameter int SYSTOLIC_SIZE    = 8,
  parameter int ACTIVATION_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  activation_skew_buffer_if.slave  bus
);
  localparam int S = SYSTOLIC_SIZE;
  localparam int W = ACTIVATION_WIDTH;
  localparam logic [1:0] MODE_SKEW   = 2'b00;
  localparam logic [1:0] MODE_DESKEW = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t         state;
  logic [1:0]     mode_q;
  logic           is_skew;
  logic           is_deskew;
  logic           ready;
  logic           accept;
  logic           load;
  logic           busy_next;
  logic [S-1:0]   lane_busy;
  logic [S-1:0]   lane_busy_next;
  logic [S-1:0]   tap_valid;
  logic [S*W-1:0] tap_data;

  assign is_skew = (mode_q == MODE_SKEW);
`ifdef STRAIT_DESKEW_EN
  assign is_deskew = (mode_q == MODE_DESKEW);
`else
  assign is_deskew = 1'b0;
`endif

  assign ready     = !rst && ((state == ST_IDLE) || ((state == ST_RUN) && (bus.mode == mode_q)));
  assign accept    = bus.valid_in && ready;
  // Delay lines are only loaded with live data when some lane has a non-zero delay.
  assign load      = accept && (is_skew || is_deskew);
  assign busy_next = |lane_busy_next;

  assign bus.ready               = ready;
  assign bus.busy                = |lane_busy;
  assign bus.valid_out           = tap_valid;
  assign bus.activation_out_flat = tap_data;

  for (genvar k = 0; k < S; k++) begin : g_lane
`ifdef STRAIT_DESKEW_EN
    localparam int NSTG = S - 1;
`else
    localparam int NSTG = k;
`endif
    logic [W-1:0] in_k;
    logic         tv;
    logic [W-1:0] td;

    assign in_k = bus.activation_in_flat[k*W +: W];

    if (NSTG > 0) begin : g_line
      localparam int SKEW_D   = k;
      localparam int DESKEW_D = S - 1 - k;
      // Masks off the final stage: its content leaves the line on the next edge.
      localparam logic [NSTG-1:0] NOT_LAST = {NSTG{1'b1}} >> 1;

      logic [NSTG-1:0]        vld;
      logic [NSTG-1:0][W-1:0] dat;
      int                     dly;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld <= '0;
          dat <= '0;
        end else begin
          vld[0] <= load;
          dat[0] <= load ? in_k : '0;
          for (int j = 1; j < NSTG; j++) begin
            vld[j] <= vld[j-1];
            dat[j] <= dat[j-1];
          end
        end
      end

      always_comb begin
        dly = 0;
        if (is_skew)
          dly = SKEW_D;
        else if (is_deskew)
          dly = DESKEW_D;
        tv = accept;
        td = accept ? in_k : '0;
        for (int j = 0; j < NSTG; j++) begin
          if (dly == j + 1) begin
            tv = vld[j];
            td = dat[j];
          end
        end
      end

      assign lane_busy[k]      = |vld;
      assign lane_busy_next[k] = load | (|(vld & NOT_LAST));
    end else begin : g_wire
      always_comb begin
        tv = accept;
        td = accept ? in_k : '0;
      end
      assign lane_busy[k]      = 1'b0;
      assign lane_busy_next[k] = 1'b0;
    end

    assign tap_valid[k]         = tv;
    assign tap_data[k*W +: W]   = tv ? td : '0;
  end

  // mode_q only moves in IDLE with empty lines, so in-flight data keeps its delays.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      mode_q <= MODE_SKEW;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load)
            state <= ST_RUN;
          else
            mode_q <= bus.mode;
        end
        ST_RUN: begin
          if (bus.mode != mode_q)
            state <= ST_DRAIN;
          else if (!busy_next)
            state <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (!busy_next)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: doc/activation_skew_buffer.md
# activation_skew_buffer

Parametrised activation skew/deskew buffer feeding the rows of the systolic array. Each of the SYSTOLIC_SIZE lanes gets a per-row delay (45-degree skew on the way in, or its mirror to deskew array outputs) or a zero-delay parallel bypass for self-test. The block adds per-lane valid tracking, bubble zeroing, an input-ready handshake and a safe drain-before-mode-switch state machine.

## Interface
- SYSTOLIC_SIZE, 8, number of lanes (≥2)
- ACTIVATION_WIDTH, 8, bits per lane
- clk  in  1  rising-edge clock
- rst  in  1  reset: one clock; reset is asynchronous and active-high
- mode  in  2  requested mode: 00 SKEW, 01 BYPASS, 10 DESKEW, 11 reserved (treated as BYPASS)
- valid_in  in  1  input vector valid
- ready  out  1  input vector accepted when valid_in && ready
- activation_in_flat  in  SYSTOLIC_SIZE*ACTIVATION_WIDTH  lane k at [k*W +: W]
- activation_out_flat  out  SYSTOLIC_SIZE*ACTIVATION_WIDTH  lane k at [k*W +: W]
- valid_out  out  SYSTOLIC_SIZE  bit k = lane k output holds live data
- busy  out  1  any lane delay stage holds valid data

## Operation
- Per lane k: shift register of SYSTOLIC_SIZE-1 stages of {valid, data}; shifts every cycle; stage 0 loads {accept, accept ? in_k : 0}, accept = valid_in && ready.
- Active mode register mode_q (reset SKEW). Lane delay d_k: SKEW d_k = k; DESKEW d_k = SYSTOLIC_SIZE-1-k; BYPASS d_k = 0.
- d_k = 0: lane output is combinational from input (gated by accept). d_k > 0: output tapped at stage d_k-1.
- Bubble zeroing: if lane's valid tap is 0, its data output is 0 (never stale data).
- busy = OR of all stage valid bits.
- FSM:
  - IDLE: busy=0. mode_q <= mode every cycle. ready=1. Accept with d_k>0 lanes → RUN.
  - RUN: ready = (mode == mode_q). If mode != mode_q → DRAIN. If busy falls to 0 with no new accept → IDLE.
  - DRAIN: ready=0; lines keep shifting zero bubbles; when busy=0 → IDLE (mode_q updates there).
- BYPASS never leaves IDLE (no stages loaded; stage 0 still loads 0).
- Mode change while idle takes effect next cycle; mode change while busy never corrupts in-flight data; every accepted vector is fully emitted in the mode it was accepted in.

## Timing
- Lane k latency = d_k cycles from accepting edge; d_k=0 lanes are same-cycle combinational.
- Back-to-back accepts sustain one vector per cycle in any mode.
- Drain time ≤ SYSTOLIC_SIZE-1 cycles after last accept.
- Reset (async, any time, including mid-RUN/DRAIN): all stages cleared, mode_q=SKEW, FSM=IDLE; while rst=1 ready=0, so valid_out=0, activation_out_flat=0, busy=0.
- First cycle after rst deassert: ready=1, mode sampled.
- valid_in while ready=0: ignored, no data loaded, no error.

## Configuration
- STRAIT_DESKEW_EN defined: mode 10 = DESKEW as above; each lane carries SYSTOLIC_SIZE-1 stages.
- Not defined: mode 10 behaves as BYPASS; lane k carries only k stages (area saving); everything else unchanged.

## Test plan
- Reset: rst=1 mid-stream with busy=1 → same cycle ready=0, all outputs 0, busy=0; after release mode_q=SKEW.
- SKEW, SIZE=8, W=8: accept vectors base 0x20,0x30,...,0x90 (lane k = base+k) on 8 consecutive cycles → lane k shows 0x20+k exactly k cycles after first accept; valid_out ramps 0x01,0x03,...,0xFF.
- BYPASS: mode=01, input base 0xA0 valid → same cycle all lanes 0xA0+k, valid_out=0xFF, busy=0; valid_in=0 → outputs 0.
- Mode switch in flight: accept 0x40-base in SKEW, next cycle mode=01 → ready=0 for 7 cycles while lane 7 still emits 0x47 at latency 7; IDLE, then BYPASS active next cycle.
- DESKEW (macro on): accept base 0x10 → lane 7 0x17 immediately, lane 0 0x10 after 7 cycles; macro off: same stimulus → all lanes same cycle.
- Bubbles: accept 0x50 base, gap cycle, accept 0x60 base in SKEW → each lane shows data, 0x00 with valid bit 0, data; no stale values.
